// File: rtl/cbus_mem_responder.sv
// Cache-bus responder: RAM-backed memory model serving single and burst reads/writes
// with a configurable idle latency before the first data beat.
package cbus_pkg;
    localparam logic [1:0] CBUS_BURST_FIXED = 2'd0;
    localparam logic [1:0] CBUS_BURST_INCR  = 2'd1;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_mem_responder
    import cbus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);
    localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
    localparam logic [3:0]  LAT_INIT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               is_write_q, is_write_d;
    logic               incr_q, incr_d;
    logic [3:0]         len_q, len_d;
    logic [3:0]         lat_q, lat_d;
    logic [3:0]         beat_q, beat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mem_we_s;
    logic [63:0]        mem [MEM_WORDS];

    // Size and out-of-range address bits carry no meaning for this memory model.
    logic unused_bits_s;
    assign unused_bits_s = ^{creq.size, creq.addr[63:IDX_W+3], creq.addr[2:0]};

    function automatic logic [63:0] byte_merge(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  strobe);
        logic [63:0] merged;
        merged = old_word;
        for (int i = 0; i < 8; i++) begin
            if (strobe[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Transaction state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            incr_q     <= 1'b0;
            len_q      <= 4'd0;
            lat_q      <= 4'd0;
            beat_q     <= 4'd0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            incr_q     <= incr_d;
            len_q      <= len_d;
            lat_q      <= lat_d;
            beat_q     <= beat_d;
            idx_q      <= idx_d;
        end
    end

    // Next-state, beat sequencing and response outputs.
    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        incr_d      = incr_q;
        len_d       = len_q;
        lat_d       = lat_q;
        beat_d      = beat_q;
        idx_d       = idx_q;
        mem_we_s    = 1'b0;
        cresp.ready = 1'b0;
        cresp.last  = 1'b0;
        cresp.data  = 64'd0;
        case (state_q)
            S_IDLE: begin
                if (creq.valid) begin
                    is_write_d = creq.is_write;
                    incr_d     = (creq.burst == CBUS_BURST_INCR);
                    len_d      = creq.len;
                    idx_d      = creq.addr[IDX_W+2:3];
                    beat_d     = 4'd0;
                    lat_d      = LAT_INIT;
                    if (LAT_INIT == 4'd0) begin
                        state_d = S_BURST;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q <= 4'd1) begin
                    state_d = S_BURST;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_BURST: begin
                cresp.ready = 1'b1;
                mem_we_s    = is_write_q;
                if (is_write_q) begin
                    cresp.data = 64'd0;
                end else begin
                    cresp.data = mem[idx_q];
                end
                if (beat_q == len_q) begin
                    cresp.last = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    beat_d  = beat_q + 4'd1;
                    state_d = S_BURST;
                    if (incr_q) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        idx_d = idx_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte-strobed memory write; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[idx_q] <= byte_merge(mem[idx_q], creq.data, creq.strobe);
        end
    end
endmodule

// File: tb/tb_cbus_mem_responder.sv
// Randomized self-checking bench for cbus_mem_responder: one instance with LATENCY=2
// and one with LATENCY=0, both checked against a sparse word-level memory model.
module tb_cbus_mem_responder;
    import cbus_pkg::*;

    localparam int WORDS = 4096;

    logic       clk = 1'b0;
    logic       reset;
    int         sel;
    cbus_req_t  req, creq0, creq1;
    cbus_resp_t cresp0, cresp1, rsp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] beat_data [16];
    logic [7:0]  beat_strb [16];
    logic [63:0] rd_data   [16];
    logic [63:0] mdl0 [int];
    logic [63:0] mdl1 [int];

    always #5 clk = ~clk;

    always_comb begin
        creq0 = (sel == 0) ? req : '0;
        creq1 = (sel == 1) ? req : '0;
        rsp   = (sel == 1) ? cresp1 : cresp0;
    end

    cbus_mem_responder #(.MEM_WORDS(WORDS), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset), .creq(creq0), .cresp(cresp0));
    cbus_mem_responder #(.MEM_WORDS(WORDS), .LATENCY(0)) u_dut1 (
        .clk(clk), .reset(reset), .creq(creq1), .cresp(cresp1));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic bit mknown(int s, int i);
        return (s == 0) ? mdl0.exists(i) : mdl1.exists(i);
    endfunction

    function automatic logic [63:0] mget(int s, int i);
        if (!mknown(s, i)) return 64'd0;
        return (s == 0) ? mdl0[i] : mdl1[i];
    endfunction

    task automatic mput(int s, int i, logic [63:0] d, logic [7:0] st);
        logic [63:0] w;
        w = mget(s, i);
        for (int b = 0; b < 8; b++)
            if (st[b]) w[8*b +: 8] = d[8*b +: 8];
        if (s == 0) mdl0[i] = w; else mdl1[i] = w;
    endtask

    // Runs one transaction starting in the current (IDLE) cycle; abort_at>=0 resets at that beat.
    task automatic do_txn(input int s, input bit wr, input logic [63:0] addr, input int len,
                          input bit incr, input int abort_at);
        int lat, first, lastc, base, k, widx;
        bit exp_ready, exp_last;
        sel   = s;
        lat   = (s == 0) ? 2 : 0;
        first = 1 + lat;
        lastc = first + len;
        base  = int'(addr[14:3]);
        req          = '0;
        req.valid    = 1'b1;
        req.is_write = wr;
        req.size     = 3'd3;
        req.addr     = addr;
        req.len      = len[3:0];
        req.burst    = incr ? CBUS_BURST_INCR : CBUS_BURST_FIXED;
        req.data     = beat_data[0];
        req.strobe   = beat_strb[0];
        for (int c = 1; c <= lastc + 1; c++) begin
            @(posedge clk); #1;
            exp_ready = (c >= first) && (c <= lastc);
            exp_last  = (c == lastc);
            k         = c - first;
            widx      = incr ? (base + k) % WORDS : base;
            if (abort_at >= 0 && exp_ready && k == abort_at) begin
                reset = 1'b0;
                #1;
                n_checks++;
                if (rsp !== '0) begin
                    n_fail++;
                    $display("FAIL abort_outputs: got %h expected 0", rsp);
                end
                @(posedge clk); #1;
                req   = '0;
                reset = 1'b1;
                return;
            end
            n_checks++;
            if (rsp.ready !== exp_ready || rsp.last !== exp_last) begin
                n_fail++;
                $display("FAIL handshake s%0d cyc%0d: got ready=%b last=%b expected ready=%b last=%b",
                         s, c, rsp.ready, rsp.last, exp_ready, exp_last);
            end
            if (!exp_ready) begin
                n_checks++;
                if (rsp.data !== 64'd0) begin
                    n_fail++;
                    $display("FAIL idle_data s%0d cyc%0d: got %h expected 0", s, c, rsp.data);
                end
            end else if (!wr) begin
                rd_data[k] = rsp.data;
                if (mknown(s, widx)) begin
                    n_checks++;
                    if (rsp.data !== mget(s, widx)) begin
                        n_fail++;
                        $display("FAIL read_data s%0d idx%0d beat%0d: got %h expected %h",
                                 s, widx, k, rsp.data, mget(s, widx));
                    end
                end
            end else begin
                req.data   = beat_data[k];
                req.strobe = beat_strb[k];
                mput(s, widx, beat_data[k], beat_strb[k]);
            end
        end
        // valid is still held through DONE; the following IDLE cycle must not respond
        @(posedge clk); #1;
        req.valid = 1'b0;
        n_checks++;
        if (rsp.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reserve s%0d: got ready=%b expected 0", s, rsp.ready);
        end
    endtask

    task automatic fill(input logic [63:0] first_val, input bit rnd);
        for (int i = 0; i < 16; i++) begin
            beat_data[i] = rnd ? {$urandom, $urandom} : first_val + 64'(i);
            beat_strb[i] = 8'hFF;
        end
    endtask

    task automatic test_reset();
        sel = 0;
        reset = 1'b0;
        req = '0;
        req.valid = 1'b1;
        req.is_write = 1'b1;
        req.addr = 64'h40;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d: got %h expected 0", i, rsp);
            end
        end
        reset = 1'b1;
        fill(64'hC0FFEE00, 1'b0);
        do_txn(0, 1'b1, 64'h40, 0, 1'b1, -1);
    endtask

    task automatic test_single();
        fill(64'h1122334455667788, 1'b0);
        do_txn(0, 1'b1, 64'h80, 0, 1'b1, -1);
        do_txn(0, 1'b0, 64'h80, 0, 1'b1, -1);
        n_checks++;
        if (rd_data[0] !== 64'h1122334455667788) begin
            n_fail++;
            $display("FAIL single_rd: got %h expected 1122334455667788", rd_data[0]);
        end
    endtask

    task automatic test_strobe();
        fill(64'hAAAAAAAAAAAAAAAA, 1'b0);
        beat_strb[0] = 8'h0F;
        do_txn(0, 1'b1, 64'h80, 0, 1'b0, -1);
        do_txn(0, 1'b0, 64'h80, 0, 1'b0, -1);
        n_checks++;
        if (rd_data[0] !== 64'h11223344AAAAAAAA) begin
            n_fail++;
            $display("FAIL strobe_rd: got %h expected 11223344aaaaaaaa", rd_data[0]);
        end
    endtask

    task automatic test_incr_burst();
        fill(64'd0, 1'b0);
        do_txn(0, 1'b1, 64'h1000, 15, 1'b1, -1);
        do_txn(0, 1'b0, 64'h1000, 15, 1'b1, -1);
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (rd_data[k] !== 64'(k)) begin
                n_fail++;
                $display("FAIL incr_rd beat%0d: got %h expected %h", k, rd_data[k], 64'(k));
            end
        end
    endtask

    task automatic test_wrap_fixed();
        fill(64'd0, 1'b1);
        do_txn(0, 1'b1, 64'h7FF8, 3, 1'b1, -1);
        do_txn(0, 1'b0, 64'h7FF8, 3, 1'b1, -1);
        do_txn(0, 1'b0, 64'h0, 0, 1'b1, -1);
        n_checks++;
        if (rd_data[0] !== beat_data[1]) begin
            n_fail++;
            $display("FAIL wrap_word0: got %h expected %h", rd_data[0], beat_data[1]);
        end
        fill(64'd1, 1'b0);
        do_txn(0, 1'b1, 64'h200, 3, 1'b0, -1);
        do_txn(0, 1'b0, 64'h200, 3, 1'b0, -1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd_data[k] !== 64'd4) begin
                n_fail++;
                $display("FAIL fixed_rd beat%0d: got %h expected 4", k, rd_data[k]);
            end
        end
    endtask

    task automatic test_lat0_reset();
        fill(64'hA000, 1'b0);
        do_txn(1, 1'b1, 64'h1000, 7, 1'b1, -1);
        fill(64'hB000, 1'b0);
        do_txn(1, 1'b1, 64'h1000, 7, 1'b1, 2);
        do_txn(1, 1'b0, 64'h1000, 7, 1'b1, -1);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (rd_data[k] !== ((k < 2) ? 64'hB000 + 64'(k) : 64'hA000 + 64'(k))) begin
                n_fail++;
                $display("FAIL abort_rd beat%0d: got %h", k, rd_data[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        int s, idx, len;
        bit wr, incr;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 4; r++) begin
                fill(64'd0, 1'b1);
                do_txn(p, 1'b1, 64'(256 + 16 * r) << 3, 15, 1'b1, -1);
            end
        for (int t = 0; t < 40; t++) begin
            s    = $urandom_range(0, 1);
            wr   = 1'($urandom_range(0, 1));
            incr = 1'($urandom_range(0, 1));
            len  = $urandom_range(0, 15);
            idx  = $urandom_range(256, 304);
            a    = {$urandom, $urandom};
            a[14:3] = idx[11:0];
            for (int i = 0; i < 16; i++) begin
                beat_data[i] = {$urandom, $urandom};
                beat_strb[i] = 8'($urandom);
            end
            do_txn(s, wr, a, len, incr, -1);
        end
    endtask

    initial begin
        sel   = 0;
        reset = 1'b0;
        req   = '0;
        test_reset();
        test_single();
        test_strobe();
        test_incr_burst();
        test_wrap_fixed();
        test_lat0_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
